// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO, FWFT read side; `UART_RX_FIFO_ERR_CNT_EN adds error counters
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_BITS-1:0]  rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_parity_err,
   input  logic                  rx_stop_err,
   output logic [DATA_BITS-1:0]  rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic [7:0]            parity_err_cnt,
   output logic [7:0]            stop_err_cnt,
   input  logic                  clr_err_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] C_ONE      = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0] C_DEPTH_M1 = (DEPTH_LOG2+1)'(DEPTH - 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} occ_state_t;

   occ_state_t             r_state;
   occ_state_t             w_state_next;
   logic [DATA_BITS-1:0]   r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  r_wr_ptr;
   logic [DEPTH_LOG2-1:0]  r_rd_ptr;
   logic [DEPTH_LOG2:0]    r_count;
   logic                   r_overflow;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_drop;

   // A full FIFO still accepts a push when the head leaves in the same cycle
   always_comb begin
      w_pop  = (r_state != ST_EMPTY) && rd_ready;
      w_push = rx_valid && ((r_state != ST_FULL) || w_pop);
      w_drop = rx_valid && (r_state == ST_FULL) && !w_pop;
   end

   // Occupancy state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_EMPTY;
      else       r_state <= w_state_next;
   end

   // Occupancy next-state and status outputs
   always_comb begin
      w_state_next = r_state;
      rd_valid     = 1'b0;
      full         = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) w_state_next = ST_PARTIAL;
         end
         ST_PARTIAL: begin
            rd_valid = 1'b1;
            if (w_push && !w_pop && (r_count == C_DEPTH_M1))
               w_state_next = ST_FULL;
            else if (w_pop && !w_push && (r_count == C_ONE))
               w_state_next = ST_EMPTY;
         end
         ST_FULL: begin
            rd_valid = 1'b1;
            full     = 1'b1;
            if (w_pop && !w_push) w_state_next = ST_PARTIAL;
         end
         default: w_state_next = ST_EMPTY;
      endcase
   end

   // Storage is not reset; only accepted characters are ever written
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= rx_data;
   end

   // Pointers wrap naturally; count moves only on unbalanced push/pop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow; a drop wins over a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)             r_overflow <= 1'b0;
      else if (w_drop)       r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
   end

   assign rd_data  = r_mem[r_rd_ptr];
   assign count    = r_count;
   assign overflow = r_overflow;

`ifdef UART_RX_FIFO_ERR_CNT_EN
   logic [7:0] r_parity_err_cnt;
   logic [7:0] r_stop_err_cnt;

   // Saturating error counters; clear with a coincident event restarts at 1
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_parity_err_cnt <= 8'd0;
         r_stop_err_cnt   <= 8'd0;
      end else if (clr_err_cnt) begin
         r_parity_err_cnt <= {7'd0, rx_parity_err};
         r_stop_err_cnt   <= {7'd0, rx_stop_err};
      end else begin
         if (rx_parity_err && (r_parity_err_cnt != 8'hFF))
            r_parity_err_cnt <= r_parity_err_cnt + 8'd1;
         if (rx_stop_err && (r_stop_err_cnt != 8'hFF))
            r_stop_err_cnt <= r_stop_err_cnt + 8'd1;
      end
   end

   assign parity_err_cnt = r_parity_err_cnt;
   assign stop_err_cnt   = r_stop_err_cnt;
`else
   logic w_unused_err;

   assign w_unused_err   = &{1'b0, rx_parity_err, rx_stop_err, clr_err_cnt};
   assign parity_err_cnt = 8'd0;
   assign stop_err_cnt   = 8'd0;
`endif

endmodule
